// File: rtl/control_lectura_buffer_pkg.sv
// Shared definitions for the pixel-buffer fetch sequencer: frame geometry
// defaults and the FSM state encoding.
package control_lectura_buffer_pkg;

    localparam int PIXELS_PER_WORD    = 4;
    localparam int IMG_COLS           = 320;
    localparam int IMG_ROWS           = 240;
    localparam int DEFAULT_IMG_WORDS  = (IMG_COLS * IMG_ROWS) / PIXELS_PER_WORD;
    localparam int DEFAULT_ADDR_WIDTH = 18;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_SAVE  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/control_lectura_buffer.sv
// Fetch sequencer: reads IMG_WORDS consecutive words from image memory and
// pushes each into the pixel buffer, one outstanding read at a time, only
// when the buffer reports space. All outputs are Moore decodes of registers.
//
// Handshakes:
//   memory side : mem_rd_req is held high with a stable mem_addr until the
//                 cycle mem_rd_ack is sampled high; mem_data_in is captured
//                 in that same cycle.
//   buffer side : save_mem_data is a one-cycle strobe with memory_data
//                 stable; space_available is re-sampled in CHECK before
//                 every read, so the buffer must update it by the cycle
//                 after a save.
module control_lectura_buffer
    import control_lectura_buffer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IMG_WORDS  = DEFAULT_IMG_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_req,
    input  logic                  mem_rd_ack,
    input  logic [31:0]           mem_data_in,
    output logic [31:0]           memory_data,
    output logic                  save_mem_data,
    input  logic                  space_available,
    output logic                  busy,
    output logic                  done
);

    localparam int                CNT_W     = $clog2(IMG_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(IMG_WORDS - 1);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      count_q;
    logic [31:0]           data_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort is only honoured at word boundaries (CHECK/SAVE)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)                state_d = ST_FIN;
                else if (space_available) state_d = ST_READ;
            end
            ST_READ: begin
                if (mem_rd_ack) state_d = ST_SAVE;
            end
            ST_SAVE: begin
                if (count_q == LAST_WORD || abort) state_d = ST_FIN;
                else                               state_d = ST_CHECK;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address counter, word counter and captured read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= BASE_ADDR;
                        count_q <= '0;
                    end
                end
                ST_READ: begin
                    if (mem_rd_ack) data_q <= mem_data_in;
                end
                ST_SAVE: begin
                    // Address wraps naturally; count never exceeds IMG_WORDS
                    addr_q  <= addr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        mem_rd_req    = (state_q == ST_READ);
        save_mem_data = (state_q == ST_SAVE);
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_FIN);
        mem_addr      = addr_q;
        memory_data   = data_q;
    end

endmodule

// File: tb/tb_control_lectura_buffer.sv
// Bench for the fetch sequencer with a three-word frame, a behavioural
// memory with programmable ack latency and a scoreboard of expected saves.
module tb_control_lectura_buffer;

    localparam int ADDR_WIDTH = 18;
    localparam int IMG_WORDS  = 3;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_req;
    logic                  mem_rd_ack;
    logic [31:0]           mem_data_in;
    logic [31:0]           memory_data;
    logic                  save_mem_data;
    logic                  space_available;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    // scoreboard of expected saves
    logic [31:0]           exp_q[$];
    logic [ADDR_WIDTH-1:0] exp_addr_q[$];
    int save_cnt = 0;
    int done_cnt = 0;

    // memory model
    logic [31:0] mem [0:7];
    int ack_delay = 0;
    int wait_cnt  = 0;

    control_lectura_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  ('0),
        .IMG_WORDS  (IMG_WORDS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .mem_addr        (mem_addr),
        .mem_rd_req      (mem_rd_req),
        .mem_rd_ack      (mem_rd_ack),
        .mem_data_in     (mem_data_in),
        .memory_data     (memory_data),
        .save_mem_data   (save_mem_data),
        .space_available (space_available),
        .busy            (busy),
        .done            (done)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory responder: acks after ack_delay waiting cycles
    initial begin
        mem_rd_ack  = 1'b0;
        mem_data_in = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_rd_req && !mem_rd_ack) begin
                if (wait_cnt >= ack_delay) begin
                    mem_rd_ack  = 1'b1;
                    mem_data_in = mem[mem_addr[2:0]];
                end else begin
                    wait_cnt++;
                end
            end else begin
                mem_rd_ack  = 1'b0;
                mem_data_in = 32'hdead_0000;
                wait_cnt    = 0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic [31:0]           ed;
        logic [ADDR_WIDTH-1:0] ea;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (save_mem_data) begin
                save_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_save: got data %h addr %0d, required no save", memory_data, mem_addr);
                end else begin
                    ed = exp_q.pop_front();
                    ea = exp_addr_q.pop_front();
                    if (memory_data !== ed || mem_addr !== ea) begin
                        errors++;
                        $display("FAIL save_data: got %h@%0d, required %h@%0d", memory_data, mem_addr, ed, ea);
                    end
                end
            end
        end
    end

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[i]);
            exp_addr_q.push_back(ADDR_WIDTH'(i));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d expected saves not seen, required 0", name, exp_q.size());
            exp_q.delete();
            exp_addr_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (mem_rd_req !== 1'b0)    begin errors++; $display("FAIL reset_req: got %b required 0", mem_rd_req); end
        if (save_mem_data !== 1'b0) begin errors++; $display("FAIL reset_save: got %b required 0", save_mem_data); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0)          begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        if (mem_addr !== '0)        begin errors++; $display("FAIL reset_addr: got %0d required 0", mem_addr); end
        if (memory_data !== '0)     begin errors++; $display("FAIL reset_data: got %h required 0", memory_data); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_frame();
        logic exp_req, exp_save, exp_done, exp_busy;
        mem[0] = 32'haabbccdd; mem[1] = 32'habcdef77; mem[2] = 32'h12345678;
        push_frame(3);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // negedge i=0 is CHECK; READ/SAVE alternate every 3 cycles
        for (int i = 0; i <= 11; i++) begin
            @(negedge clk);
            exp_req  = (i == 1 || i == 4 || i == 7);
            exp_save = (i == 2 || i == 5 || i == 8);
            exp_done = (i == 9);
            exp_busy = (i <= 9);
            checks++;
            if ({mem_rd_req, save_mem_data, done, busy} !== {exp_req, exp_save, exp_done, exp_busy}) begin
                errors++;
                $display("FAIL frame_timing cyc%0d: req/save/done/busy %b%b%b%b required %b%b%b%b",
                         i, mem_rd_req, save_mem_data, done, busy, exp_req, exp_save, exp_done, exp_busy);
            end
        end
        check_sb_empty("frame");
    endtask

    task automatic test_space_stall();
        int s0 = save_cnt;
        mem[0] = 32'h01010101; mem[1] = 32'h02020202; mem[2] = 32'h03030303;
        push_frame(3);
        space_available = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_rd_req !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_cyc%0d: req %b busy %b, required req 0 busy 1", i, mem_rd_req, busy);
            end
        end
        @(posedge clk); #1;
        space_available = 1'b1;
        wait_done("stall", 40);
        @(negedge clk);
        checks++;
        if (save_cnt - s0 != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d saves required 3", save_cnt - s0);
        end
        check_sb_empty("stall");
    endtask

    task automatic test_ack_delay();
        int s0;
        int guard = 0;
        logic [ADDR_WIDTH-1:0] a0;
        mem[0] = 32'hcafe0000; mem[1] = 32'hcafe0001; mem[2] = 32'hcafe0002;
        push_frame(3);
        ack_delay = 4;
        pulse_start();
        while (!mem_rd_req && guard < 20) begin @(negedge clk); guard++; end
        checks++;
        if (!mem_rd_req) begin errors++; $display("FAIL ackdly_req_timeout: req %b required 1", mem_rd_req); end
        a0 = mem_addr;
        s0 = save_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_rd_req !== 1'b1 || mem_addr !== a0 || save_mem_data !== 1'b0) begin
                errors++;
                $display("FAIL ackdly_hold%0d: req %b addr %0d save %b, required 1 %0d 0",
                         i, mem_rd_req, mem_addr, save_mem_data, a0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (save_cnt - s0 != 1) begin
            errors++;
            $display("FAIL ackdly_one_save: got %0d saves required 1", save_cnt - s0);
        end
        wait_done("ackdly", 80);
        ack_delay = 0;
        check_sb_empty("ackdly");
    endtask

    task automatic test_abort();
        int s0 = save_cnt;
        int d0 = done_cnt;
        int guard = 0;
        mem[0] = 32'h0badf00d; mem[1] = 32'h00c0ffee; mem[2] = 32'hffffffff;
        push_frame(2);
        pulse_start();
        while (!(mem_rd_req && mem_addr == 1) && guard < 20) begin @(negedge clk); guard++; end
        abort = 1'b1;
        start = 1'b1;
        wait_done("abort", 20);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mem_rd_req !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle%0d: busy %b req %b required 0 0", i, busy, mem_rd_req);
            end
        end
        checks += 2;
        if (save_cnt - s0 != 2) begin errors++; $display("FAIL abort_words: got %0d required 2", save_cnt - s0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done_cnt: got %0d required 1", done_cnt - d0); end
        check_sb_empty("abort");
    endtask

    task automatic test_start_abort();
        int s0 = save_cnt;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_rd_req !== 1'b0) begin
            errors++; $display("FAIL sa_check: busy %b req %b required 1 0", busy, mem_rd_req);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL sa_done: got %b required 1", done); end
        abort = 1'b0;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL sa_busy: got %b required 0", busy); end
        if (save_cnt != s0) begin errors++; $display("FAIL sa_words: got %0d required 0", save_cnt - s0); end
    endtask

    task automatic test_reset_mid();
        int s0, d0;
        int guard = 0;
        mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
        push_frame(1);
        ack_delay = 10;
        pulse_start();
        while (!(mem_rd_req && mem_addr == 1) && guard < 40) begin @(negedge clk); guard++; end
        s0 = save_cnt;
        d0 = done_cnt;
        reset = 1'b0;
        @(negedge clk);
        checks += 4;
        if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
        if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b required 0", mem_rd_req); end
        if (mem_addr !== '0)     begin errors++; $display("FAIL rmid_addr: got %0d required 0", mem_addr); end
        if (memory_data !== '0)  begin errors++; $display("FAIL rmid_data: got %h required 0", memory_data); end
        reset = 1'b1;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (save_cnt != s0 || done_cnt != d0) begin
            errors++;
            $display("FAIL rmid_quiet: saves %0d dones %0d after reset, required 0 0", save_cnt - s0, done_cnt - d0);
        end
        check_sb_empty("rmid_first");
        mem[0] = 32'h44444444; mem[1] = 32'h55555555; mem[2] = 32'h66666666;
        push_frame(3);
        pulse_start();
        wait_done("rmid_refetch", 40);
        check_sb_empty("rmid_refetch");
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        space_available = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_frame();
        test_space_stall();
        test_ack_delay();
        test_abort();
        test_start_abort();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
